// File: rtl/log_reader.sv
`default_nettype none
// ============================================================================
//  Module      : log_reader
//  Description : Read-out side of the log RAM. Once the log RAM is full
//                (i_rdy_log), walks the RAM from address 0 to RAM_DEPTH-1,
//                one word per micro NEXT command, and presents each word with
//                a valid flag for micro readback. Commands are edge-detected
//                on the held micro command register.
//  Revision    : 1.0 - initial release
// ============================================================================
module log_reader #(
    parameter int LOG_RAM_EXP      = 15,
    parameter int NB_DATA          = 32,
    parameter int NB_MICRO_COMMAND = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NB_MICRO_COMMAND-1:0] i_micro_com,
    input  logic                        i_rdy_log,
    input  logic [NB_DATA-1:0]          i_ram_data,
    output logic [LOG_RAM_EXP-1:0]      o_ram_addr,
    output logic [NB_DATA-1:0]          o_data,
    output logic                        o_data_valid,
    output logic                        o_read_done
);

    // Micro command codes; every other value is ignored.
    localparam logic [NB_MICRO_COMMAND-1:0] c_cmd_start = NB_MICRO_COMMAND'(50);
    localparam logic [NB_MICRO_COMMAND-1:0] c_cmd_next  = NB_MICRO_COMMAND'(51);
    localparam logic [NB_MICRO_COMMAND-1:0] c_cmd_abort = NB_MICRO_COMMAND'(53);

    // Last word address: the counter stops here and never wraps.
    localparam logic [LOG_RAM_EXP-1:0] c_last_addr = {LOG_RAM_EXP{1'b1}};

    // FSM state encoding.
    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_fetch   = 3'd1;
    localparam logic [2:0] c_st_capture = 3'd2;
    localparam logic [2:0] c_st_hold    = 3'd3;
    localparam logic [2:0] c_st_done    = 3'd4;

    logic [2:0]                  state_q,      state_d;
    logic [LOG_RAM_EXP-1:0]      counter_q,    counter_d;
    logic [NB_DATA-1:0]          data_q,       data_d;
    logic                        data_valid_q, data_valid_d;
    logic                        read_done_q,  read_done_d;
    logic [NB_MICRO_COMMAND-1:0] prev_com_q,   prev_com_d;

    logic w_ev_start;
    logic w_ev_next;
    logic w_ev_abort;
    logic w_start_ok;

    // Rising-edge detection of each command level: a held command yields
    // one event only; the micro must write another value to repeat it.
    always_comb begin
        w_ev_start = (i_micro_com == c_cmd_start) && (prev_com_q != c_cmd_start);
        w_ev_next  = (i_micro_com == c_cmd_next)  && (prev_com_q != c_cmd_next);
        w_ev_abort = (i_micro_com == c_cmd_abort) && (prev_com_q != c_cmd_abort);
        // i_rdy_log only gates START; dropping it mid-read has no effect.
        w_start_ok = w_ev_start && i_rdy_log;
    end

    // Next-state logic. ABORT overrides everything; events that do not
    // apply to the current state are dropped rather than queued.
    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        data_d       = data_q;
        data_valid_d = data_valid_q;
        read_done_d  = read_done_q;
        prev_com_d   = i_micro_com;

        if (w_ev_abort) begin
            // o_data is deliberately left holding the last captured word.
            state_d      = c_st_idle;
            counter_d    = '0;
            data_valid_d = 1'b0;
            read_done_d  = 1'b0;
        end else begin
            case (state_q)
                c_st_idle: begin
                    if (w_start_ok) begin
                        state_d   = c_st_fetch;
                        counter_d = '0;
                    end
                end
                c_st_fetch: begin
                    // Address is on o_ram_addr this cycle; the RAM returns
                    // the word one clock later.
                    state_d = c_st_capture;
                end
                c_st_capture: begin
                    // Only place o_data changes, so it is stable while valid.
                    state_d      = c_st_hold;
                    data_d       = i_ram_data;
                    data_valid_d = 1'b1;
                end
                c_st_hold: begin
                    if (w_ev_next) begin
                        data_valid_d = 1'b0;
                        if (counter_q == c_last_addr) begin
                            state_d     = c_st_done;
                            read_done_d = 1'b1;
                        end else begin
                            state_d   = c_st_fetch;
                            counter_d = counter_q + 1'b1;
                        end
                    end
                end
                c_st_done: begin
                    if (w_start_ok) begin
                        state_d     = c_st_fetch;
                        counter_d   = '0;
                        read_done_d = 1'b0;
                    end
                end
                default: begin
                    state_d      = c_st_idle;
                    counter_d    = '0;
                    data_valid_d = 1'b0;
                    read_done_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= c_st_idle;
            counter_q    <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            read_done_q  <= 1'b0;
            prev_com_q   <= '0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            read_done_q  <= read_done_d;
            prev_com_q   <= prev_com_d;
        end
    end

    // The RAM address is the word counter in every state.
    always_comb begin
        o_ram_addr   = counter_q;
        o_data       = data_q;
        o_data_valid = data_valid_q;
        o_read_done  = read_done_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_log_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_log_reader
//  Description : Self-checking bench for log_reader (16-word RAM). Directed
//                scenarios followed by randomized command traffic, all
//                checked every cycle against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_log_reader;

    localparam int LOG_RAM_EXP = 4;
    localparam int NB_DATA     = 32;
    localparam int NB_COM      = 8;
    localparam int DEPTH       = 1 << LOG_RAM_EXP;
    localparam logic [31:0] WBASE = 32'hA000_0000;

    logic                   clk;
    logic                   rst;
    logic [NB_COM-1:0]      micro_com;
    logic                   rdy_log;
    logic [NB_DATA-1:0]     ram_data;
    logic [LOG_RAM_EXP-1:0] ram_addr;
    logic [NB_DATA-1:0]     data;
    logic                   data_valid;
    logic                   read_done;

    int checks = 0;
    int errors = 0;

    // Reference model: reader mode, current word index, word-ready countdown
    localparam int M_IDLE = 0, M_READING = 1, M_DONE = 2;
    int          m_mode;
    int          m_idx;
    int          m_wait;      // clocks until the requested word is shown
    logic        m_valid;
    logic        m_done;
    logic [31:0] m_data;
    logic [7:0]  m_prev;

    log_reader #(
        .LOG_RAM_EXP      (LOG_RAM_EXP),
        .NB_DATA          (NB_DATA),
        .NB_MICRO_COMMAND (NB_COM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_micro_com  (micro_com),
        .i_rdy_log    (rdy_log),
        .i_ram_data   (ram_data),
        .o_ram_addr   (ram_addr),
        .o_data       (data),
        .o_data_valid (data_valid),
        .o_read_done  (read_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log RAM with registered read: word[a] = A000_0000 + a
    always @(posedge clk) ram_data <= WBASE + 32'(ram_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model update for one clock edge, using the inputs seen at that edge.
    // A requested word becomes visible two clocks after the command is seen.
    task automatic model_edge();
        logic st, nx, ab;
        if (rst) begin
            m_mode = M_IDLE; m_idx = 0; m_wait = 0;
            m_valid = 1'b0; m_done = 1'b0; m_data = 32'h0; m_prev = 8'h0;
            return;
        end
        st = (micro_com == 8'd50) && (m_prev != 8'd50);
        nx = (micro_com == 8'd51) && (m_prev != 8'd51);
        ab = (micro_com == 8'd53) && (m_prev != 8'd53);
        if (ab) begin
            m_mode = M_IDLE; m_idx = 0; m_wait = 0; m_valid = 1'b0; m_done = 1'b0;
        end else if (st && rdy_log && m_mode != M_READING) begin
            m_mode = M_READING; m_idx = 0; m_wait = 2; m_valid = 1'b0; m_done = 1'b0;
        end else if (nx && m_mode == M_READING && m_valid) begin
            m_valid = 1'b0;
            if (m_idx == DEPTH - 1) begin
                m_mode = M_DONE; m_done = 1'b1;
            end else begin
                m_idx++; m_wait = 2;
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                m_valid = 1'b1;
                m_data  = WBASE + 32'(m_idx);
            end
        end
        m_prev = micro_com;
    endtask

    // Drive inputs, take one clock, then compare all outputs with the model.
    task automatic cyc(input logic [7:0] com, input logic rdy, input logic r);
        micro_com = com; rdy_log = rdy; rst = r;
        @(posedge clk);
        model_edge();
        #1;
        check("valid", 32'(data_valid), 32'(m_valid));
        check("done",  32'(read_done),  32'(m_done));
        check("addr",  32'(ram_addr),   32'(m_idx));
        check("data",  data,            m_data);
    endtask

    task automatic start_read();
        cyc(8'd50, 1'b1, 1'b0); cyc(8'd0, 1'b1, 1'b0); cyc(8'd0, 1'b1, 1'b0);
    endtask

    task automatic next_word();
        cyc(8'd51, 1'b1, 1'b0); cyc(8'd0, 1'b1, 1'b0); cyc(8'd0, 1'b1, 1'b0);
    endtask

    initial begin
        int r, hold;
        logic [7:0] com;
        logic rdy, rs;
        micro_com = 8'd0; rdy_log = 1'b0; rst = 1'b1;
        m_mode = M_IDLE; m_idx = 0; m_wait = 0;
        m_valid = 1'b0; m_done = 1'b0; m_data = 32'h0; m_prev = 8'h0;

        // 1: reset held then released
        repeat (3) cyc(8'd0, 1'b0, 1'b1);
        cyc(8'd0, 1'b0, 1'b0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_done",  32'(read_done),  32'd0);
        check("rst_addr",  32'(ram_addr),   32'd0);

        // 2: START without rdy ignored; with rdy first word after 3 clocks
        repeat (5) cyc(8'd50, 1'b0, 1'b0);
        check("norody_valid", 32'(data_valid), 32'd0);
        cyc(8'd0, 1'b1, 1'b0);
        cyc(8'd50, 1'b1, 1'b0);
        cyc(8'd50, 1'b1, 1'b0);
        check("start_lat_early", 32'(data_valid), 32'd0);
        cyc(8'd50, 1'b1, 1'b0);
        check("start_lat_valid", 32'(data_valid), 32'd1);
        check("start_word0",     data,            32'hA000_0000);
        cyc(8'd0, 1'b1, 1'b0);

        // 3: walk all 16 words
        for (int i = 0; i < DEPTH; i++) begin
            check("walk_word", data, WBASE + 32'(i));
            cyc(8'd51, 1'b1, 1'b0);
            if (i < DEPTH - 1) begin
                cyc(8'd0, 1'b1, 1'b0); cyc(8'd0, 1'b1, 1'b0);
            end
        end
        check("end_done",  32'(read_done),  32'd1);
        check("end_valid", 32'(data_valid), 32'd0);
        check("end_addr",  32'(ram_addr),   32'd15);
        repeat (4) cyc(8'd51, 1'b1, 1'b0);
        check("done_sticky", 32'(read_done), 32'd1);
        cyc(8'd0, 1'b1, 1'b0);

        // 4: NEXT held for 10 clocks advances once
        start_read();
        repeat (10) cyc(8'd51, 1'b1, 1'b0);
        check("held_next_addr", 32'(ram_addr), 32'd1);
        check("held_next_data", data, WBASE + 32'd1);
        cyc(8'd0, 1'b0, 1'b0);   // rdy dropped mid-read: read continues

        // 5: ABORT at word 5, then restart from word 0
        repeat (4) next_word();
        check("at_word5", data, WBASE + 32'd5);
        cyc(8'd53, 1'b1, 1'b0);
        check("abort_addr",  32'(ram_addr),   32'd0);
        check("abort_valid", 32'(data_valid), 32'd0);
        check("abort_keep",  data,            WBASE + 32'd5);
        cyc(8'd0, 1'b1, 1'b0);
        start_read();
        check("restart_word0", data, WBASE);

        // 6: reset in HOLD at word 7
        repeat (7) next_word();
        check("at_word7", data, WBASE + 32'd7);
        cyc(8'd0, 1'b1, 1'b1);
        check("rst7_data",  data,            32'd0);
        check("rst7_valid", 32'(data_valid), 32'd0);
        check("rst7_addr",  32'(ram_addr),   32'd0);
        start_read();
        check("rst_restart_word0", data, WBASE);

        // Randomized command traffic
        for (int k = 0; k < 1500; k++) begin
            r = $urandom_range(0, 99);
            if (r < 35)      com = 8'd51;
            else if (r < 50) com = 8'd50;
            else if (r < 53) com = 8'd53;
            else if (r < 85) com = 8'd0;
            else             com = 8'($urandom_range(0, 255));
            hold = $urandom_range(1, 4);
            rdy  = ($urandom_range(0, 9) != 0);
            rs   = ($urandom_range(0, 299) == 0);
            for (int j = 0; j < hold; j++) cyc(com, rdy, rs && (j == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
